// File: rtl/serial_compa_ctrl.sv
// Serial MSB-first magnitude comparator sequencer driving one shared external
// one-digit comparator, with start/busy/done handshake and three-LED result.
module serial_compa_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_A,
  output logic             cmp_B,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             led_A_lt_B,
  output logic             led_A_eq_B,
  output logic             led_A_gt_B,
  output logic [CW-1:0]    steps,
  output logic             err
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic [CW-1:0]    steps_q, steps_d;
  logic             err_q, err_d;
  logic             onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      steps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      steps_q <= steps_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    onehot = 1'b0;
    case ({cmp_lt, cmp_eq, cmp_gt})
      3'b100, 3'b010, 3'b001: onehot = 1'b1;
      default:                onehot = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    steps_d = steps_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = IW'(WIDTH - 1);
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          steps_d = '0;
          err_d   = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Count every examined pair; saturate so a bad idx can never overflow it
        if (steps_q != CW'(WIDTH)) begin
          steps_d = CW'(steps_q + CW'(1));
        end
        if (!onehot) begin
          err_d   = 1'b1;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = S_DONE;
        end else if (cmp_gt) begin
          gt_d    = 1'b1;
          state_d = S_DONE;
        end else if (cmp_lt) begin
          lt_d    = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = IW'(idx_q - IW'(1));
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Comparator operands come straight from the captured operands, gated to SCAN
  assign cmp_A      = (state_q == S_SCAN) & a_q[idx_q];
  assign cmp_B      = (state_q == S_SCAN) & b_q[idx_q];
  assign busy       = (state_q == S_SCAN) | (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign led_A_lt_B = lt_q;
  assign led_A_eq_B = eq_q;
  assign led_A_gt_B = gt_q;
  assign steps      = steps_q;
  assign err        = err_q;

endmodule

// File: tb/tb_serial_compa_ctrl.sv
// Self-checking bench for serial_compa_ctrl: the bench plays the external
// one-digit comparator and checks against an arithmetic reference model.
module tb_serial_compa_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             cmp_A, cmp_B;
  logic             cmp_lt, cmp_eq, cmp_gt;
  logic             busy, done;
  logic             led_A_lt_B, led_A_eq_B, led_A_gt_B;
  logic [CW-1:0]    steps;
  logic             err;

  // Fault injection on the comparator feedback: kind 0 = eq+gt, kind 1 = none
  logic f_on;
  logic f_kind;

  int checks = 0;
  int errors = 0;

  serial_compa_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .cmp_A      (cmp_A),
    .cmp_B      (cmp_B),
    .cmp_lt     (cmp_lt),
    .cmp_eq     (cmp_eq),
    .cmp_gt     (cmp_gt),
    .busy       (busy),
    .done       (done),
    .led_A_lt_B (led_A_lt_B),
    .led_A_eq_B (led_A_eq_B),
    .led_A_gt_B (led_A_gt_B),
    .steps      (steps),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign cmp_lt = f_on ? 1'b0 : (!cmp_A && cmp_B);
  assign cmp_eq = f_on ? !f_kind : (cmp_A == cmp_B);
  assign cmp_gt = f_on ? !f_kind : (cmp_A && !cmp_B);

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pairs examined: up to and including the most significant differing bit
  function automatic int ref_steps(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] diff;
    diff = a ^ b;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) return WIDTH - i;
    end
    return WIDTH;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk1({tag, "_cmpA"}, cmp_A, 1'b0);
    chk1({tag, "_cmpB"}, cmp_B, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_lt"}, led_A_lt_B, 1'b0);
    chk1({tag, "_eq"}, led_A_eq_B, 1'b0);
    chk1({tag, "_gt"}, led_A_gt_B, 1'b0);
    chkn({tag, "_steps"}, 32'(steps), 32'd0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  // One full operation: fcyc>0 injects a fault on that SCAN cycle; chg scrambles a_in mid-scan
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int fcyc, input logic fkind, input bit chg);
    int  k;
    bit  e_err;
    logic [WIDTH-1:0] av, bv;
    av = a;
    bv = b;
    k = ref_steps(a, b);
    e_err = 1'b0;
    if (fcyc > 0 && fcyc <= k) begin
      k = fcyc;
      e_err = 1'b1;
    end
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= k; c++) begin
      f_on   = (c == fcyc);
      f_kind = fkind;
      if (chg && c == 2) begin
        a_in = 8'hFF;
        b_in = 8'h00;
      end
      chk1("scan_busy", busy, 1'b1);
      chk1("scan_done", done, 1'b0);
      chk1("scan_cmpA", cmp_A, av[WIDTH-c]);
      chk1("scan_cmpB", cmp_B, bv[WIDTH-c]);
      chk1("scan_leds_clear", led_A_lt_B | led_A_eq_B | led_A_gt_B, 1'b0);
      tick();
    end
    f_on = 1'b0;
    chk1("done_pulse", done, 1'b1);
    chk1("done_busy", busy, 1'b1);
    chk1("done_cmpA", cmp_A, 1'b0);
    chk1("done_lt", led_A_lt_B, !e_err && (av < bv));
    chk1("done_eq", led_A_eq_B, !e_err && (av == bv));
    chk1("done_gt", led_A_gt_B, !e_err && (av > bv));
    chkn("done_steps", 32'(steps), 32'(k));
    chk1("done_err", err, e_err);
    tick();
    chk1("idle_done", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_hold_eq", led_A_eq_B, !e_err && (av == bv));
    chkn("idle_hold_steps", 32'(steps), 32'(k));
  endtask

  initial begin
    int k;
    int dcnt;
    logic [WIDTH-1:0] ra, rb;
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    f_on   = 1'b0;
    f_kind = 1'b0;
    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();

    run_op(8'hA5, 8'hA5, 0, 1'b0, 1'b0);
    run_op(8'h80, 8'h7F, 0, 1'b0, 1'b0);
    run_op(8'h12, 8'h13, 0, 1'b0, 1'b1);

    // start held high: exactly one done pulse, next op accepted from the IDLE cycle
    a_in  = 8'h3C;
    b_in  = 8'h3A;
    k     = ref_steps(8'h3C, 8'h3A);
    start = 1'b1;
    tick();
    dcnt = 0;
    for (int c = 1; c <= k + 1; c++) begin
      if (done) dcnt++;
      if (c <= k) tick();
    end
    chkn("hold_done_count", 32'(dcnt), 32'd1);
    chk1("hold_gt", led_A_gt_B, 1'b1);
    tick();
    chk1("hold_idle_busy", busy, 1'b0);
    tick();
    chk1("hold_reaccept_busy", busy, 1'b1);
    start = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= k; c++) begin
      if (done) dcnt++;
      tick();
    end
    chkn("hold_second_early_done", 32'(dcnt), 32'd0);
    chk1("hold_second_done", done, 1'b1);
    chkn("hold_second_steps", 32'(steps), 32'(k));
    tick();

    // Reset in the third SCAN cycle aborts with no done pulse
    a_in  = 8'h55;
    b_in  = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk1("abort_pre_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk_idle_zero("abort");
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < WIDTH + 2; c++) begin
      if (done || busy) dcnt++;
      tick();
    end
    chkn("abort_no_done", 32'(dcnt), 32'd0);
    run_op(8'h01, 8'h00, 0, 1'b0, 1'b0);

    // eq+gt both asserted on the first SCAN cycle
    run_op(8'hC3, 8'hC3, 1, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0)
        run_op(ra, rb, int'($urandom_range(1, WIDTH)), 1'($urandom_range(0, 1)), 1'b0);
      else
        run_op(ra, rb, 0, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_compa_ctrl.md
Name: serial_compa_ctrl

Overview:
Sequencer that compares two WIDTH-bit unsigned operands by sharing one external one-digit comparator. It compares bit pairs MSB-first and stops at the first unequal pair. The comparator's lt/eq/gt outputs feed back to this block. It drives the same three-LED result indication as the single-digit comparator, plus a start/busy/done handshake for board-level or FSM use.

Parameters:
WIDTH, 8, operand width in bits (>=2)
CW, $clog2(WIDTH+1), width of the step counter output

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request a comparison; sampled only in IDLE
a_in  in  WIDTH  operand A, captured when start is accepted
b_in  in  WIDTH  operand B, captured when start is accepted
cmp_A  out  1  bit of A presented to the external one-digit comparator
cmp_B  out  1  bit of B presented to the external one-digit comparator
cmp_lt  in  1  comparator result A<B for (cmp_A, cmp_B), combinational
cmp_eq  in  1  comparator result A==B, combinational
cmp_gt  in  1  comparator result A>B, combinational
busy  out  1  high in SCAN and DONE
done  out  1  one-cycle pulse when the result is valid
led_A_lt_B  out  1  final result A<B
led_A_eq_B  out  1  final result A==B
led_A_gt_B  out  1  final result A>B
steps  out  CW  number of bit pairs examined for the last result (1..WIDTH)
err  out  1  comparator feedback not one-hot during the last operation

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: cmp_A, cmp_B, busy, done, all three LEDs, steps, err.
  - Internal operand registers and the index are cleared.
  - Reset overrides everything. A scan in progress is aborted and produces no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Previous LEDs, steps and err are held.
  - If start=1 at an edge: latch a_in and b_in, set idx=WIDTH-1, clear LEDs, steps and err, go to SCAN.
- SCAN:
  - cmp_A = a_reg[idx] and cmp_B = b_reg[idx], driven combinationally from registers. Both are 0 outside SCAN.
  - The cmp_* results are sampled at the edge ending each SCAN cycle, and steps increments at that edge.
  - Fault: if {cmp_lt, cmp_eq, cmp_gt} is not exactly one-hot, set err=1, all LEDs 0, go to DONE.
  - If cmp_gt=1: led_A_gt_B=1, go to DONE.
  - If cmp_lt=1: led_A_lt_B=1, go to DONE.
  - If cmp_eq=1 and idx==0: led_A_eq_B=1, go to DONE.
  - If cmp_eq=1 and idx>0: idx decrements, stay in SCAN.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE.
  - start is ignored in DONE. Back-to-back operations need one IDLE cycle.
- Latency:
  - start is accepted at edge E0. k bit pairs are examined in cycles 1..k.
  - done is high in cycle k+1. LEDs and steps are valid from cycle k+1 and held until the next accepted start.
  - Worst case (equal operands): done in cycle WIDTH+1.
- At most one LED is ever high. All three are 0 after reset, while a new scan is running, and after a fault.
- start during SCAN or DONE has no effect, and a_in/b_in changes during SCAN do not alter the result.
- steps saturates structurally at WIDTH. The index never wraps below 0.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start pulse -> cmp_A/cmp_B walk bits 7..0, done in cycle 9 after acceptance, led_A_eq_B=1, steps=8, err=0.
- a=0x80, b=0x7F -> single SCAN cycle (cmp_A=1, cmp_B=0), done in cycle 2, led_A_gt_B=1, steps=1.
- a=0x12, b=0x13 -> bits 7..1 equal, bit0 lt, done in cycle 9, led_A_lt_B=1, steps=8. Then change a_in mid-scan to 0xFF -> result unchanged.
- Start held high through SCAN and DONE -> only one operation runs, exactly one done pulse. The next operation is accepted in the IDLE cycle that follows.
- rst=1 at the third SCAN cycle -> next cycle all outputs 0, no done pulse. A subsequent start with a=0x01, b=0x00 completes with gt and steps=8.
- Bench forces cmp_eq=1 and cmp_gt=1 on the first SCAN cycle -> err=1, all LEDs 0, done in cycle 2, steps=1.
